// File: rtl/dmx_pkg.sv
// rtl/dmx_pkg.sv - shared DMX constants, FSM state type and level expansion helper
package dmx_pkg;

    localparam int DMX_SLOTS = 512;
    localparam int DMX_CH_W  = 9;
    localparam int PWM_W     = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } fade_state_t;

    // Replicating the byte maps 0x00 to 0x0000 and 0xFF to full scale 0xFFFF.
    function automatic logic [PWM_W-1:0] expand8to16(input logic [7:0] d);
        return {d, d};
    endfunction

endpackage

// File: rtl/dmx_fader.sv
// rtl/dmx_fader.sv - per-channel slew limiter between DMX receiver and PWM duty inputs
module dmx_fader
    import dmx_pkg::*;
#(
    parameter int CHANNELS     = 8,
    parameter int BASE_CHANNEL = 0,
    parameter int TICK_DIV     = 48000,
    parameter int STEP         = 256
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      write_strobe,
    input  logic [DMX_CH_W-1:0]       channel,
    input  logic [7:0]                data,
    input  logic                      fade_enable,
    output logic [CHANNELS*PWM_W-1:0] values,
    output logic                      busy
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [9:0]       SLOT_LO  = 10'(BASE_CHANNEL);
    localparam logic [9:0]       SLOT_HI  = 10'(BASE_CHANNEL + CHANNELS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHANNELS - 1);
    localparam logic [PWM_W:0]   STEP_17  = 17'(STEP);
    localparam logic [PWM_W-1:0] STEP_16  = 16'(STEP);

    if (TICK_DIV < CHANNELS + 1) begin : g_bad_tick_div
        $error("dmx_fader: TICK_DIV must be >= CHANNELS+1");
    end
    if (CHANNELS < 1 || CHANNELS > 64) begin : g_bad_channels
        $error("dmx_fader: CHANNELS must be 1..64");
    end
    if (STEP < 1 || STEP > 65535) begin : g_bad_step
        $error("dmx_fader: STEP must be 1..65535");
    end

    logic [PWM_W-1:0] tgt_q [CHANNELS];
    logic [PWM_W-1:0] cur_q [CHANNELS];

    fade_state_t      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_d;
    logic             upd_en;

    logic [CNT_W-1:0] cnt_q;
    logic             tick;

    // Write decode
    logic [9:0]       slot_ext;
    logic [9:0]       slot_off;
    logic             slot_hit;
    logic [IDX_W-1:0] wr_idx;

    assign slot_ext = {1'b0, channel};
    assign slot_off = slot_ext - SLOT_LO;
    assign slot_hit = write_strobe && (slot_ext >= SLOT_LO) && (slot_ext < SLOT_HI);
    assign wr_idx   = slot_off[IDX_W-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                tgt_q[i] <= '0;
            end
        end else if (slot_hit) begin
            tgt_q[wr_idx] <= expand8to16(data);
        end
    end

    assign tick = (cnt_q == CNT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy;
        upd_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_SCAN: begin
                upd_en = 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Shared datapath: one subtractor for the gap, one adder for the step.
    logic [PWM_W-1:0] cur_sel, tgt_sel, cur_next;
    logic [PWM_W:0]   diff, gap;
    logic             rising;

    assign cur_sel = cur_q[idx_q];
    assign tgt_sel = tgt_q[idx_q];
    assign diff    = {1'b0, tgt_sel} - {1'b0, cur_sel};
    assign rising  = ~diff[PWM_W];
    assign gap     = rising ? diff : (~diff + 1'b1);

    always_comb begin
        cur_next = tgt_sel;
        if (fade_enable && (gap > STEP_17)) begin
            cur_next = cur_sel + (rising ? STEP_16 : (~STEP_16 + 1'b1));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cur_q[i] <= '0;
            end
        end else if (upd_en) begin
            cur_q[idx_q] <= cur_next;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_values
        assign values[g*PWM_W +: PWM_W] = cur_q[g];
    end

endmodule
